// File: rtl/tone_sequencer_if.sv
// Transport, score-memory and playback signals of tone_sequencer.
// master = the sequencer itself, slave = the surrounding system.
interface tone_sequencer_if #(
  parameter int AW = 6
);
  logic          tick_i;
  logic          play_i;
  logic          stop_i;
  logic          pause_i;
  logic          loop_i;
  logic [AW-1:0] score_addr_o;
  logic [11:0]   score_data_i;
  logic [5:0]    note_idx_o;
  logic          gate_o;
  logic          busy_o;
  logic          done_o;

  modport master (
    input  tick_i, play_i, stop_i, pause_i, loop_i, score_data_i,
    output score_addr_o, note_idx_o, gate_o, busy_o, done_o
  );

  modport slave (
    output tick_i, play_i, stop_i, pause_i, loop_i, score_data_i,
    input  score_addr_o, note_idx_o, gate_o, busy_o, done_o
  );
endinterface

// File: rtl/tone_sequencer.sv
// Score-walking playback controller with play/stop/pause/loop transport.
// Define TONE_SEQUENCER_GAP_EN to insert a one-tick silent GAP after each non-rest event.
module tone_sequencer #(
  parameter int AW        = 6,
  parameter int SCORE_LEN = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  tone_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    PLAY,
`ifdef TONE_SEQUENCER_GAP_EN
    GAP,
`endif
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [5:0]    note_q, note_d;
  logic          gate_q, gate_d;
  logic          rest_q, rest_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          busy_q, done_q;
  logic          advance;
  logic          last_addr;

  assign last_addr = (addr_q == AW'(SCORE_LEN - 1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    note_d  = note_q;
    gate_d  = gate_q;
    rest_d  = rest_q;
    cnt_d   = cnt_q;
    advance = 1'b0;

    if (bus.stop_i) begin
      state_d = IDLE;
      addr_d  = '0;
      gate_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.play_i) begin
            addr_d  = '0;
            state_d = FETCH;
          end
        end
        FETCH: state_d = LOAD;
        LOAD: begin
          if (bus.score_data_i[11]) begin
            // an end marker at address 0 must finish, or looping would spin forever
            if (bus.loop_i && addr_q != '0) begin
              addr_d  = '0;
              state_d = FETCH;
            end else begin
              gate_d  = 1'b0;
              state_d = DONE;
            end
          end else begin
            note_d  = bus.score_data_i[5:0];
            rest_d  = bus.score_data_i[10];
            gate_d  = ~bus.score_data_i[10];
            cnt_d   = bus.score_data_i[9:6];
            state_d = PLAY;
          end
        end
        PLAY: begin
          if (bus.pause_i) begin
            gate_d = 1'b0;
          end else begin
            gate_d = ~rest_q;
            if (bus.tick_i) begin
              if (cnt_q != '0) begin
                cnt_d = cnt_q - 4'd1;
              end else begin
`ifdef TONE_SEQUENCER_GAP_EN
                if (!rest_q) begin
                  gate_d  = 1'b0;
                  state_d = GAP;
                end else begin
                  advance = 1'b1;
                end
`else
                advance = 1'b1;
`endif
              end
            end
          end
        end
`ifdef TONE_SEQUENCER_GAP_EN
        GAP: begin
          if (!bus.pause_i && bus.tick_i) advance = 1'b1;
        end
`endif
        DONE: begin
          gate_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      if (advance) begin
        if (last_addr && !bus.loop_i) begin
          gate_d  = 1'b0;
          state_d = DONE;
        end else begin
          addr_d  = last_addr ? '0 : addr_q + AW'(1);
          state_d = FETCH;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      note_q  <= '0;
      gate_q  <= 1'b0;
      rest_q  <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      note_q  <= note_d;
      gate_q  <= gate_d;
      rest_q  <= rest_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  assign bus.score_addr_o = addr_q;
  assign bus.note_idx_o   = note_q;
  assign bus.gate_o       = gate_q;
  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;

endmodule
